imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Shares the single synchronous port of the instruction memory between the core's fetch stage and the program loader. Holds the core stalled in a boot phase while the loader writes the program image, then switches to run mode. In run mode fetch has priority, but the loader is guaranteed a slot after a bounded wait. Sits between IF stage / loader and the instruction memory array; substitutes a NOP (0x00000013) whenever no valid fetch data is returned.

## Interface
- ADDR_W, 10: memory word-address width (2^ADDR_W words)
- MAX_WAIT, 4: consecutive cycles a pending loader request may lose to fetch before it is forced through (1..15)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch read request
- fetch_addr  in  32  fetch byte address
- fetch_gnt  out  1  fetch request accepted this cycle (combinational)
- fetch_rvalid  out  1  fetch_rdata valid (registered)
- fetch_rdata  out  32  instruction word; 0x00000013 when fetch_rvalid=0
- fetch_err  out  1  registered; accepted fetch was misaligned or out of range
- ld_req  in  1  loader write request
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_done  in  1  single-cycle pulse: image complete
- ld_gnt  out  1  loader write accepted this cycle (combinational)
- ld_err  out  1  registered; accepted write was out of range and was dropped
- core_stall  out  1  registered; high in BOOT state
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address (byte address bits [ADDR_W+1:2])
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid one cycle after mem_en with mem_we=0

## Operation
- States: BOOT, RUN. Reset -> BOOT. BOOT -> RUN on ld_done (takes effect the next cycle). RUN -> BOOT only on rst.
- BOOT: fetch_gnt=0 regardless of fetch_req; ld_gnt=ld_req.
- A write accepted in the same cycle as ld_done still completes.
- RUN arbitration:
  - fetch_gnt = fetch_req && !force.
  - ld_gnt = ld_req && (!fetch_req || force).
  - force = (wait_cnt == MAX_WAIT).
- wait_cnt (4 bits):
  - Increments when ld_req=1 and ld_gnt=0.
  - Clears when ld_gnt=1 or ld_req=0.
  - Saturates at MAX_WAIT.
- At most one grant per cycle. mem_en = fetch_gnt || ld_gnt; mem_we = ld_gnt.
- mem_addr comes from the granted requester; mem_addr=0 and mem_wdata=0 when idle.
- Range check: address in range iff byte address bits [31:ADDR_W+2] are all zero.
- Loader write with an out-of-range address: ld_gnt=1, mem_en=0, mem_we=0; ld_err=1 the next cycle.
- Loader ld_addr[1:0] are ignored (word write).
- Fetch with fetch_addr[1:0]!=0 or out of range: fetch_gnt=1, memory not accessed; next cycle fetch_rvalid=1, fetch_rdata=NOP, fetch_err=1.
- Normal fetch: next cycle fetch_rvalid=1, fetch_rdata=mem_rdata, fetch_err=0.
- The memory is write-first across cycles: a write in cycle N is visible to a fetch granted in cycle N+1.

## Timing
- Grant is same-cycle combinational from req, state and wait_cnt.
- Read data latency is exactly 1 cycle after fetch_gnt; throughput is 1 fetch per cycle.
- Back-to-back fetches return back-to-back rvalid.
- Reset values: state=BOOT, core_stall=1, wait_cnt=0, fetch_rvalid=0, fetch_err=0, ld_err=0, fetch_rdata=NOP.
- During reset: fetch_gnt=0, ld_gnt=0, mem_en=0.
- Reset mid-operation: a fetch granted in the cycle rst is asserted produces no rvalid; a concurrent write is not issued.
- core_stall falls in the cycle after ld_done is sampled, i.e. the same cycle state becomes RUN.
- ld_done while already in RUN is ignored.
- ld_err and fetch_err are single-cycle pulses per offending access.

## Test plan
- Boot load: write 0x00500293 @0x4 and 0x00130313 @0x8 in BOOT, while fetch_req=1 throughout. Required: fetch_gnt=0 and core_stall=1; then pulse ld_done -> core_stall=0 next cycle. Fetch 0x4 -> one cycle later fetch_rvalid=1, fetch_rdata=0x00500293.
- Fetch priority and forcing (MAX_WAIT=4): in RUN hold fetch_req=1 and ld_req=1. Required: fetch granted 4 cycles, ld_gnt on the 5th with fetch_gnt=0, then fetch regains the grant; repeats every 5 cycles.
- Write-then-read: loader writes 0x00000073 @0x20 in cycle N, fetch of 0x20 in N+1. Required: rdata=0x00000073 in N+2.
- Errors: fetch 0x6 -> rvalid=1, rdata=0x00000013, fetch_err=1, mem_en=0. Loader write 0x1000 with ADDR_W=10 -> ld_gnt=1, mem_we=0, ld_err=1 the next cycle, memory unchanged.
- Reset mid-stream: in RUN with a fetch granted, assert rst for one cycle. Required: no rvalid next cycle, state=BOOT, core_stall=1, fetch_gnt=0 until a new ld_done.
- Idle: no requests in RUN. Required: mem_en=0, fetch_rvalid=0, fetch_rdata=0x00000013, wait_cnt stays 0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares the single synchronous instruction-memory port between the fetch
//   stage and the program loader. After reset the core is held stalled (BOOT)
//   while the loader writes the image. Once ld_done is seen, the arbiter enters
//   RUN. In RUN, fetch has priority over the loader, but a loader that keeps
//   losing is forced through after MAX_WAIT cycles.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   fetch_req/addr      : fetch read request and byte address
//   fetch_gnt           : fetch accepted this cycle (combinational)
//   fetch_rvalid/rdata  : registered read response; rdata is NOP when not valid
//   fetch_err           : registered; the accepted fetch was misaligned or out of range
//   ld_req/addr/wdata   : loader word-write request
//   ld_done             : one-cycle pulse that ends the boot phase
//   ld_gnt              : loader write accepted this cycle (combinational)
//   ld_err              : registered; the accepted write was out of range and dropped
//   core_stall          : registered; high while in BOOT
//   mem_en/we/addr/wdata: memory port strobe, write enable, word address and data
//   mem_rdata           : memory read data, valid one cycle after a read
module imem_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [31:0]       fetch_rdata,
   output logic              fetch_err,
   input  logic              ld_req,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_wdata,
   input  logic              ld_done,
   output logic              ld_gnt,
   output logic              ld_err,
   output logic              core_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [3:0]  WAIT_LIM = 4'(MAX_WAIT);

   typedef enum logic {BOOT, RUN} state_t;

   state_t     state, state_nxt;
   logic [3:0] wait_cnt, wait_nxt;
   logic       force_ld;
   logic       fetch_ok, ld_ok;
   logic       fetch_hit, ld_hit;
   logic       ld_addr_unused;

   // Loader writes whole words, so the byte offset is ignored.
   assign ld_addr_unused = ^ld_addr[1:0];

   assign fetch_ok = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:ADDR_W+2] == '0);
   assign ld_ok    = (ld_addr[31:ADDR_W+2] == '0);
   assign force_ld = (wait_cnt == WAIT_LIM);

   // Next state and grants. Reset masks every grant in the same cycle, so a
   // request presented while rst is high never reaches the memory.
   always_comb begin
      state_nxt = state;
      fetch_gnt = 1'b0;
      ld_gnt    = 1'b0;
      unique case (state)
         BOOT: begin
            ld_gnt = ld_req;
            if (ld_done) state_nxt = RUN;
         end
         RUN: begin
            fetch_gnt = fetch_req && !force_ld;
            ld_gnt    = ld_req && (!fetch_req || force_ld);
         end
         default: state_nxt = BOOT;
      endcase
      if (rst) begin
         fetch_gnt = 1'b0;
         ld_gnt    = 1'b0;
         state_nxt = BOOT;
      end
   end

   // Count the cycles a pending loader request has lost in a row. When the
   // count reaches the limit, the loader is forced through on the next cycle.
   always_comb begin
      wait_nxt = 4'd0;
      if (ld_req && !ld_gnt)
         wait_nxt = force_ld ? wait_cnt : wait_cnt + 4'd1;
   end

   // Rejected accesses are still granted, but they never touch the memory.
   assign fetch_hit = fetch_gnt && fetch_ok;
   assign ld_hit    = ld_gnt && ld_ok;

   assign mem_en    = fetch_hit || ld_hit;
   assign mem_we    = ld_hit;
   assign mem_addr  = fetch_hit ? fetch_addr[ADDR_W+1:2] :
                      ld_hit    ? ld_addr[ADDR_W+1:2]    : '0;
   assign mem_wdata = ld_hit ? ld_wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         core_stall   <= 1'b1;
         wait_cnt     <= 4'd0;
         fetch_rvalid <= 1'b0;
         fetch_err    <= 1'b0;
         ld_err       <= 1'b0;
      end else begin
         state        <= state_nxt;
         core_stall   <= (state_nxt == BOOT);
         wait_cnt     <= wait_nxt;
         fetch_rvalid <= fetch_gnt;
         fetch_err    <= fetch_gnt && !fetch_ok;
         ld_err       <= ld_gnt && !ld_ok;
      end
   end

   // The memory output already has one cycle of latency, so the response
   // only has to be muxed. A faulted fetch did not access the memory, so it
   // returns NOP.
   assign fetch_rdata = (fetch_rvalid && !fetch_err) ? mem_rdata : NOP;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter. It uses a behavioural 1-cycle
// synchronous memory, a vector table for the single-cycle behaviour, and
// hand-written sequences for forced loader slots and reset mid-stream.
module tb_imem_port_arbiter;

   localparam int          ADDR_W = 10;
   localparam logic        H      = 1'b1;
   localparam logic        L      = 1'b0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst;
   logic              fetch_req, fetch_gnt, fetch_rvalid, fetch_err;
   logic [31:0]       fetch_addr, fetch_rdata;
   logic              ld_req, ld_done, ld_gnt, ld_err, core_stall;
   logic [31:0]       ld_addr, ld_wdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = 32'h0;
   logic [31:0]       mem [0:(1<<ADDR_W)-1] = '{default: 32'h0};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
      .ld_gnt(ld_gnt), .ld_err(ld_err), .core_stall(core_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory model: registered read, and writes visible from the next cycle.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic        frq;  logic [31:0] fa;
      logic        lrq;  logic [31:0] la;  logic [31:0] lw;  logic dn;
      logic        fg;   logic lg;  logic en;  logic we;
      logic [ADDR_W-1:0] ma; logic [31:0] mw;
      logic        st;   logic rv;  logic [31:0] rd;  logic fe;  logic le;
   } vec_t;

   vec_t vecs [0:16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic frq, input logic [31:0] fa, input logic lrq,
                        input logic [31:0] la, input logic [31:0] lw, input logic dn);
      fetch_req = frq; fetch_addr = fa;
      ld_req = lrq; ld_addr = la; ld_wdata = lw; ld_done = dn;
   endtask

   initial begin
      // Each row lists: inputs | same-cycle grants and port | registered outputs from the last edge
      vecs[0]  = '{H,32'h4,    H,32'h4,   32'h00500293,L, L,H,H,H,10'd1,32'h00500293, H,L,NOP,L,L};
      vecs[1]  = '{H,32'h4,    H,32'h8,   32'h00130313,H, L,H,H,H,10'd2,32'h00130313, H,L,NOP,L,L};
      vecs[2]  = '{H,32'h4,    L,32'h0,   32'h0,       L, H,L,H,L,10'd1,32'h0,        L,L,NOP,L,L};
      vecs[3]  = '{H,32'h8,    L,32'h0,   32'h0,       L, H,L,H,L,10'd2,32'h0,        L,H,32'h00500293,L,L};
      vecs[4]  = '{L,32'h0,    L,32'h0,   32'h0,       L, L,L,L,L,10'd0,32'h0,        L,H,32'h00130313,L,L};
      vecs[5]  = '{L,32'h0,    L,32'h0,   32'h0,       L, L,L,L,L,10'd0,32'h0,        L,L,NOP,L,L};
      vecs[6]  = '{L,32'h0,    H,32'h20,  32'h00000073,L, L,H,H,H,10'd8,32'h00000073, L,L,NOP,L,L};
      vecs[7]  = '{H,32'h20,   L,32'h0,   32'h0,       L, H,L,H,L,10'd8,32'h0,        L,L,NOP,L,L};
      vecs[8]  = '{L,32'h0,    L,32'h0,   32'h0,       L, L,L,L,L,10'd0,32'h0,        L,H,32'h00000073,L,L};
      vecs[9]  = '{H,32'h6,    L,32'h0,   32'h0,       L, H,L,L,L,10'd0,32'h0,        L,L,NOP,L,L};
      vecs[10] = '{L,32'h0,    H,32'h1000,32'hDEADBEEF,L, L,H,L,L,10'd0,32'h0,        L,H,NOP,H,L};
      vecs[11] = '{H,32'h1000, L,32'h0,   32'h0,       L, H,L,L,L,10'd0,32'h0,        L,L,NOP,L,H};
      vecs[12] = '{H,32'h0,    L,32'h0,   32'h0,       L, H,L,H,L,10'd0,32'h0,        L,H,NOP,H,L};
      vecs[13] = '{L,32'h0,    L,32'h0,   32'h0,       L, L,L,L,L,10'd0,32'h0,        L,H,32'h0,L,L};
      vecs[14] = '{L,32'h0,    H,32'h25,  32'h11111111,H, L,H,H,H,10'd9,32'h11111111, L,L,NOP,L,L};
      vecs[15] = '{H,32'h24,   L,32'h0,   32'h0,       L, H,L,H,L,10'd9,32'h0,        L,L,NOP,L,L};
      vecs[16] = '{L,32'h0,    L,32'h0,   32'h0,       L, L,L,L,L,10'd0,32'h0,        L,H,32'h11111111,L,L};

      // Reset with both requesters active.
      rst = 1'b1;
      drive(H, 32'h4, H, 32'h4, 32'h1, L);
      repeat (2) @(negedge clk);
      #2;
      chk("rst fetch_gnt",    32'(fetch_gnt),    32'h0);
      chk("rst ld_gnt",       32'(ld_gnt),       32'h0);
      chk("rst mem_en",       32'(mem_en),       32'h0);
      chk("rst core_stall",   32'(core_stall),   32'h1);
      chk("rst fetch_rvalid", 32'(fetch_rvalid), 32'h0);
      chk("rst fetch_rdata",  fetch_rdata,       NOP);
      chk("rst fetch_err",    32'(fetch_err),    32'h0);
      chk("rst ld_err",       32'(ld_err),       32'h0);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         drive(vecs[i].frq, vecs[i].fa, vecs[i].lrq, vecs[i].la, vecs[i].lw, vecs[i].dn);
         #2;
         chk($sformatf("v%0d fetch_gnt", i),    32'(fetch_gnt),    32'(vecs[i].fg));
         chk($sformatf("v%0d ld_gnt", i),       32'(ld_gnt),       32'(vecs[i].lg));
         chk($sformatf("v%0d mem_en", i),       32'(mem_en),       32'(vecs[i].en));
         chk($sformatf("v%0d mem_we", i),       32'(mem_we),       32'(vecs[i].we));
         chk($sformatf("v%0d mem_addr", i),     32'(mem_addr),     32'(vecs[i].ma));
         chk($sformatf("v%0d mem_wdata", i),    mem_wdata,         vecs[i].mw);
         chk($sformatf("v%0d core_stall", i),   32'(core_stall),   32'(vecs[i].st));
         chk($sformatf("v%0d fetch_rvalid", i), 32'(fetch_rvalid), 32'(vecs[i].rv));
         chk($sformatf("v%0d fetch_rdata", i),  fetch_rdata,       vecs[i].rd);
         chk($sformatf("v%0d fetch_err", i),    32'(fetch_err),    32'(vecs[i].fe));
         chk($sformatf("v%0d ld_err", i),       32'(ld_err),       32'(vecs[i].le));
         @(negedge clk);
      end

      // Contention: the loader must win exactly every fifth cycle.
      begin
         logic prev_fg;
         logic exp_lg;
         prev_fg = 1'b0;
         for (int k = 0; k < 10; k++) begin
            drive(H, 32'h4, H, 32'h40, 32'(k), L);
            #2;
            exp_lg = (k % 5 == 4);
            chk($sformatf("arb%0d ld_gnt", k),       32'(ld_gnt),       32'(exp_lg));
            chk($sformatf("arb%0d fetch_gnt", k),    32'(fetch_gnt),    32'(!exp_lg));
            chk($sformatf("arb%0d mem_we", k),       32'(mem_we),       32'(exp_lg));
            chk($sformatf("arb%0d fetch_rvalid", k), 32'(fetch_rvalid), 32'(prev_fg));
            if (prev_fg)
               chk($sformatf("arb%0d fetch_rdata", k), fetch_rdata, 32'h00500293);
            prev_fg = !exp_lg;
            @(negedge clk);
         end
      end

      // Reset in the middle of traffic: the write must not be issued and fetch must not return data.
      rst = 1'b1;
      drive(H, 32'h4, H, 32'h44, 32'hABCD, L);
      #2;
      chk("mrst fetch_gnt", 32'(fetch_gnt), 32'h0);
      chk("mrst ld_gnt",    32'(ld_gnt),    32'h0);
      chk("mrst mem_en",    32'(mem_en),    32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(H, 32'h4, L, 32'h0, 32'h0, L);
      #2;
      chk("mrst+1 fetch_rvalid", 32'(fetch_rvalid), 32'h0);
      chk("mrst+1 core_stall",   32'(core_stall),   32'h1);
      chk("mrst+1 fetch_gnt",    32'(fetch_gnt),    32'h0);
      chk("mrst+1 mem_en",       32'(mem_en),       32'h0);
      @(negedge clk);
      #2;
      chk("mrst+2 fetch_gnt",    32'(fetch_gnt),    32'h0);
      @(negedge clk);
      drive(H, 32'h4, L, 32'h0, 32'h0, H);
      #2;
      chk("mrst+3 fetch_gnt",    32'(fetch_gnt),    32'h0);
      chk("mrst+3 core_stall",   32'(core_stall),   32'h1);
      @(negedge clk);
      drive(H, 32'h44, L, 32'h0, 32'h0, L);
      #2;
      chk("mrst+4 core_stall",   32'(core_stall),   32'h0);
      chk("mrst+4 fetch_gnt",    32'(fetch_gnt),    32'h1);
      chk("mrst+4 mem_addr",     32'(mem_addr),     32'h11);
      @(negedge clk);
      drive(L, 32'h0, L, 32'h0, 32'h0, L);
      #2;
      chk("mrst+5 fetch_rvalid", 32'(fetch_rvalid), 32'h1);
      chk("mrst+5 fetch_rdata",  fetch_rdata,       32'h0);
      @(negedge clk);
      #2;
      chk("idle fetch_rvalid",   32'(fetch_rvalid), 32'h0);
      chk("idle fetch_rdata",    fetch_rdata,       NOP);
      chk("idle mem_en",         32'(mem_en),       32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
